// File: rtl/reg_operand_reader.sv
// Read-side sequencer for a 2-entry register file: fetches an operand pair with two
// single-port reads and hands it downstream. Optional write snooping: WRITE_BYPASS_EN.
module reg_operand_reader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr_a,
   input  logic [ADDR_W-1:0] req_addr_b,
   output logic              rf_rd_en,
   output logic [ADDR_W-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0] rf_rd_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, DONE} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addrA;
   logic [ADDR_W-1:0] addrB;

   // Handshake: a transfer happens on any rising edge where valid && ready; valid never
   // waits on ready. req_ready depends combinationally on op_ready only in DONE.
   assign req_ready = rst_n && ((state == IDLE) || ((state == DONE) && op_ready));

`ifdef WRITE_BYPASS_EN
   logic bypA;
   logic bypB;
   logic hitA;
   logic hitB;

   assign hitA = wr_en && (wr_addr == addrA);
   assign hitB = wr_en && (wr_addr == addrB);
`else
   logic unusedSnoop;

   assign unusedSnoop = ^{wr_en, wr_addr, wr_data};
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_valid   <= 1'b0;
         op_a       <= '0;
         op_b       <= '0;
         rf_rd_en   <= 1'b0;
         rf_rd_addr <= '0;
         addrA      <= '0;
         addrB      <= '0;
`ifdef WRITE_BYPASS_EN
         bypA       <= 1'b0;
         bypB       <= 1'b0;
`endif
      end else begin
         rf_rd_en   <= 1'b0;
         rf_rd_addr <= '0;
         case (state)
            IDLE, DONE: begin
               if ((state == IDLE) || op_ready) begin
                  op_valid <= 1'b0;
                  if (req_valid) begin
                     // Read strobe is registered, so it is launched with the acceptance.
                     addrA      <= req_addr_a;
                     addrB      <= req_addr_b;
                     rf_rd_en   <= 1'b1;
                     rf_rd_addr <= req_addr_a;
                     state      <= RD_A;
`ifdef WRITE_BYPASS_EN
                     bypA       <= 1'b0;
                     bypB       <= 1'b0;
`endif
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            RD_A: begin
               rf_rd_en   <= 1'b1;
               rf_rd_addr <= addrB;
               state      <= RD_B;
`ifdef WRITE_BYPASS_EN
               if (hitA) begin
                  op_a <= wr_data;
                  bypA <= 1'b1;
               end
               if (hitB) begin
                  op_b <= wr_data;
                  bypB <= 1'b1;
               end
`endif
            end
            RD_B: begin
               state <= CAP_B;
`ifdef WRITE_BYPASS_EN
               // The A read returns pre-write data, so an earlier snoop must win over it.
               if (hitA) op_a <= wr_data;
               else if (!bypA) op_a <= rf_rd_data;
               if (hitB) begin
                  op_b <= wr_data;
                  bypB <= 1'b1;
               end
`else
               op_a <= rf_rd_data;
`endif
            end
            CAP_B: begin
               state    <= DONE;
               op_valid <= 1'b1;
`ifdef WRITE_BYPASS_EN
               if (hitA) op_a <= wr_data;
               if (hitB) op_b <= wr_data;
               else if (!bypB) op_b <= rf_rd_data;
`else
               op_b <= rf_rd_data;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_operand_reader.sv
// Bench for reg_operand_reader: directed test-plan sequences, then random traffic
// scored against a transaction-level model built from register-file snapshots.
module tb_reg_operand_reader;

   localparam int MAXC = 4000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [0:0] req_addr_a;
   logic [0:0] req_addr_b;
   logic       rf_rd_en;
   logic [0:0] rf_rd_addr;
   logic [7:0] rf_rd_data;
   logic       wr_en;
   logic [0:0] wr_addr;
   logic [7:0] wr_data;
   logic       op_valid;
   logic       op_ready;
   logic [7:0] op_a;
   logic [7:0] op_b;

   reg_operand_reader #(.DATA_W(8), .ADDR_W(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
      .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b)
   );

   // clock / reset
   always #5 clk = ~clk;

   int nChecks = 0;
   int nFails  = 0;
   int cyc     = 0;

   // Behavioural register file: read-before-write, preloaded during the reset cycles.
   logic [7:0] mem [0:1];
   always @(posedge clk) begin
      if (cyc < 2) begin
         mem[0]     <= 8'h04;
         mem[1]     <= 8'h05;
         rf_rd_data <= 8'h00;
      end else begin
         if (rf_rd_en) rf_rd_data <= mem[rf_rd_addr];
         if (wr_en) mem[wr_addr] <= wr_data;
      end
   end

   // scoreboard
   logic [15:0] exp_q[$];
   logic [7:0]  memHist [0:MAXC][0:1];
   logic        wrEnLog   [0:MAXC];
   logic [0:0]  wrAddrLog [0:MAXC];
   logic [7:0]  wrDataLog [0:MAXC];
   bit          haveTxn    = 1'b0;
   int          tAcc       = -100;
   logic [0:0]  txA, txB;
   bit          prevRstLow = 1'b1;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      nChecks++;
      if (got !== want) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Register contents at the read cycle, replaced by the last matching write in the window.
   function automatic logic [7:0] expOperand(input int t, input int readCyc, input logic [0:0] a);
      logic [7:0] v;
      v = memHist[readCyc][a];
`ifdef WRITE_BYPASS_EN
      for (int c = t + 1; c <= t + 3; c++)
         if (wrEnLog[c] && (wrAddrLog[c] == a)) v = wrDataLog[c];
`endif
      return v;
   endfunction

   // driver: one full clock cycle of stimulus plus output checks
   task automatic cycle(input bit rv, input bit [0:0] aa, input bit [0:0] ab, input bit ordy,
                        input bit we, input bit [0:0] wa, input bit [7:0] wd, input bit rn);
      bit         expValid, expRdEn, expReqReady;
      logic [0:0] expRdAddr;
      @(negedge clk);
      cyc++;
      memHist[cyc][0] = mem[0];
      memHist[cyc][1] = mem[1];
      expValid  = haveTxn && (cyc >= tAcc + 4);
      expRdEn   = haveTxn && ((cyc == tAcc + 1) || (cyc == tAcc + 2));
      expRdAddr = (haveTxn && cyc == tAcc + 2) ? txB : (haveTxn && cyc == tAcc + 1) ? txA : 1'b0;
      if (haveTxn && cyc == tAcc + 4)
         exp_q.push_back({expOperand(tAcc, tAcc + 1, txA), expOperand(tAcc, tAcc + 2, txB)});
      check("op_valid", 16'(op_valid), 16'(expValid));
      check("rf_rd_en", 16'(rf_rd_en), 16'(expRdEn));
      check("rf_rd_addr", 16'(rf_rd_addr), 16'(expRdAddr));
      if (expValid && exp_q.size() > 0) check("operands", {op_a, op_b}, exp_q[0]);
      else if (prevRstLow) check("reset_operands", {op_a, op_b}, 16'h0000);

      rst_n      = rn;
      req_valid  = rv;
      req_addr_a = aa;
      req_addr_b = ab;
      op_ready   = ordy;
      wr_en      = we;
      wr_addr    = wa;
      wr_data    = wd;
      wrEnLog[cyc]   = we;
      wrAddrLog[cyc] = wa;
      wrDataLog[cyc] = wd;
      #1;
      expReqReady = rn && (!haveTxn || (expValid && ordy));
      check("req_ready", 16'(req_ready), 16'(expReqReady));

      if (!rn) begin
         haveTxn = 1'b0;
         exp_q.delete();
      end else begin
         if (expValid && ordy) begin
            haveTxn = 1'b0;
            void'(exp_q.pop_front());
         end
         if (rv && expReqReady) begin
            haveTxn = 1'b1;
            tAcc    = cyc;
            txA     = aa;
            txB     = ab;
         end
      end
      prevRstLow = !rn;
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b1; req_addr_a = 1'b0; req_addr_b = 1'b0;
      op_ready = 1'b0; wr_en = 1'b0; wr_addr = 1'b0; wr_data = 8'h00;

      // reset held with a pending request
      repeat (2) cycle(1, 0, 1, 0, 0, 0, 8'h00, 0);
      check("reset_op_a", 16'(op_a), 16'h0000);
      cycle(0, 0, 0, 0, 0, 0, 8'h00, 1);
      check("ready_after_reset", 16'(req_ready), 16'h0001);

      // basic fetch, then backpressure with a request waiting
      cycle(1, 0, 1, 0, 0, 0, 8'h00, 1);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 8'h00, 1);
      cycle(1, 1, 1, 0, 0, 0, 8'h00, 1);
      check("basic_op_a", 16'(op_a), 16'h0004);
      check("basic_op_b", 16'(op_b), 16'h0005);
      repeat (4) cycle(1, 1, 1, 0, 0, 0, 8'h00, 1);
      check("held_op_a", 16'(op_a), 16'h0004);

      // back-to-back acceptance from DONE, same register for both operands
      cycle(1, 1, 1, 1, 0, 0, 8'h00, 1);
      repeat (3) cycle(0, 0, 0, 0, 0, 0, 8'h00, 1);
      cycle(1, 0, 1, 1, 0, 0, 8'h00, 1);
      check("same_reg_op_a", 16'(op_a), 16'h0005);
      check("same_reg_op_b", 16'(op_b), 16'h0005);

      // write to register 0 during RD_A
      cycle(0, 0, 0, 0, 1, 0, 8'h3C, 1);
      repeat (2) cycle(0, 0, 0, 0, 0, 0, 8'h00, 1);
      cycle(0, 0, 0, 1, 0, 0, 8'h00, 1);
`ifdef WRITE_BYPASS_EN
      check("bypass_op_a", 16'(op_a), 16'h003C);
`else
      check("bypass_op_a", 16'(op_a), 16'h0004);
`endif
      check("bypass_op_b", 16'(op_b), 16'h0005);

      // reset during RD_B aborts the fetch
      cycle(1, 1, 0, 0, 0, 0, 8'h00, 1);
      cycle(0, 0, 0, 0, 0, 0, 8'h00, 1);
      cycle(0, 0, 0, 0, 0, 0, 8'h00, 0);
      repeat (4) cycle(0, 0, 0, 0, 0, 0, 8'h00, 1);

      // random traffic with occasional resets
      for (int i = 0; i < 1500; i++)
         cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), $urandom_range(0, 99) != 0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
